// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle between the load/store unit (master) and data memory (slave).
// Latency: none, wires only.
// Backpressure: the master holds its request until the slave pulses dmem_resp.
interface mem_access_unit_if;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_mbe, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I data-memory access unit: aligned address, byte mask, lane-replicated store data, load extension.
// Latency: 3 cycles with a zero-wait memory (op, request, done), plus one per memory wait cycle.
// Backpressure: stall_o freezes the pipeline until dmem_resp or the MAX_WAIT watchdog; MEM_MISALIGN_TRAP_EN enables misalignment trapping.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   mem_read_i,
    input  logic                   mem_write_i,
    input  logic [2:0]             funct3_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            wdata_i,
    mem_access_unit_if.master      dmem,
    output logic                   stall_o,
    output logic [31:0]            load_data_o,
    output logic                   load_valid_o,
    output logic                   timeout_o,
    output logic                   misaligned_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

    state_t      state;
    logic [31:0] addr_q;
    logic        read_q;
    logic        write_q;
    logic [3:0]  mbe_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        op_read_q;
    logic [15:0] wait_cnt;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic        timeout_q;

    logic        op_present;
    logic [3:0]  mbe_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign op_present = valid_i && (mem_read_i || mem_write_i);

    // Byte mask and lane-replicated store data for the incoming op; upper mask bits shift out.
    always_comb begin
        mbe_c   = 4'hF;
        wdata_c = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                mbe_c   = 4'b0001 << addr_i[1:0];
                wdata_c = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                mbe_c   = 4'b0011 << addr_i[1:0];
                wdata_c = {2{wdata_i[15:0]}};
            end
            default: begin
                mbe_c   = 4'hF;
                wdata_c = wdata_i;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_c;
    logic misaligned_q;
    assign misaligned_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                          ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    assign misaligned_o = misaligned_q;
`else
    assign misaligned_o = 1'b0;
`endif

    // Pick the addressed byte/half from the returned word and extend per the captured funct3.
    always_comb begin
        byte_sel = 8'(dmem.dmem_rdata >> {off_q, 3'b000});
        half_sel = 16'(dmem.dmem_rdata >> {off_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    // Access FSM: capture in IDLE, hold request in ACCESS until resp/watchdog, release in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= 32'h0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            mbe_q        <= 4'h0;
            wdata_q      <= 32'h0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            op_read_q    <= 1'b0;
            wait_cnt     <= 16'h0;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            load_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (op_present) begin
`ifdef MEM_MISALIGN_TRAP_EN
                        if (misaligned_c) begin
                            misaligned_q <= 1'b1;
                            state        <= DONE;
                        end else begin
`else
                        begin
`endif
                            addr_q    <= {addr_i[31:2], 2'b00};
                            mbe_q     <= mbe_c;
                            wdata_q   <= wdata_c;
                            funct3_q  <= funct3_i;
                            off_q     <= addr_i[1:0];
                            op_read_q <= mem_read_i;
                            read_q    <= mem_read_i;
                            write_q   <= !mem_read_i;
                            wait_cnt  <= 16'h0;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_resp) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        if (op_read_q) begin
                            load_data_q  <= load_ext;
                            load_valid_q <= 1'b1;
                        end
                        state <= DONE;
                    end else if ((WAIT_LIMIT != 16'h0) && (wait_cnt == WAIT_LIMIT - 16'd1)) begin
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        load_data_q <= 32'h0;
                        timeout_q   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall while a new op is being accepted or a request is outstanding; reset forces it low.
    assign stall_o = (state == ACCESS) || ((state == IDLE) && op_present && !rst);

    assign dmem.dmem_address = addr_q;
    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_mbe     = mbe_q;
    assign dmem.dmem_wdata   = wdata_q;
    assign load_data_o       = load_data_q;
    assign load_valid_o      = load_valid_q;
    assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a hand-driven memory responder (MAX_WAIT=4).
// Latency: each op is run until stall_o releases; cycle counts are compared against hand values.
// Backpressure: dmem_resp is asserted after a per-op number of wait cycles, or never for the watchdog case.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        timeout_o;
    logic        misaligned_o;

    mem_access_unit_if dmem ();

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .dmem         (dmem),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .timeout_o    (timeout_o),
        .misaligned_o (misaligned_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations collected by do_op
    int          stall_cnt, req_cnt, lv_cnt, to_cnt, mis_cnt, total;
    logic        obs_read, obs_write;
    logic [31:0] obs_addr, obs_wdata, lv_data, to_data;
    logic [3:0]  obs_mbe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge that leaves DONE.
    // waits < 0 means the memory never responds.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int waits);
        bit fin;
        valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        funct3_i = f3; addr_i = a; wdata_i = wd;
        stall_cnt = 0; req_cnt = 0; lv_cnt = 0; to_cnt = 0; mis_cnt = 0; total = 0;
        obs_read = 0; obs_write = 0; obs_addr = 0; obs_wdata = 0; obs_mbe = 0;
        lv_data = 0; to_data = 32'hFFFF_FFFF;
        fin = 0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (dmem.dmem_read || dmem.dmem_write) begin
                if (req_cnt == 0) begin
                    obs_read  = dmem.dmem_read;
                    obs_write = dmem.dmem_write;
                    obs_addr  = dmem.dmem_address;
                    obs_mbe   = dmem.dmem_mbe;
                    obs_wdata = dmem.dmem_wdata;
                end
                req_cnt++;
                if (waits >= 0 && req_cnt == waits + 1) begin
                    dmem.dmem_resp  = 1'b1;
                    dmem.dmem_rdata = rdat;
                end
            end
            if (load_valid_o) begin lv_cnt++; lv_data = load_data_o; end
            if (timeout_o) begin to_cnt++; to_data = load_data_o; end
            if (misaligned_o) mis_cnt++;
            if (c > 0 && !stall_o) begin fin = 1; total = c + 1; end
            @(posedge clk); #1;
            valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
            dmem.dmem_resp = 1'b0;
        end
        chk("op_completed", {31'h0, fin}, 32'h1);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        valid_i = 0; mem_read_i = 0; mem_write_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
        dmem.dmem_resp = 1'b0; dmem.dmem_rdata = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read",   {31'h0, dmem.dmem_read}, 32'h0);
        chk("rst_write",  {31'h0, dmem.dmem_write}, 32'h0);
        chk("rst_addr",   dmem.dmem_address, 32'h0);
        chk("rst_mbe",    {28'h0, dmem.dmem_mbe}, 32'h0);
        chk("rst_wdata",  dmem.dmem_wdata, 32'h0);
        chk("rst_stall",  {31'h0, stall_o}, 32'h0);
        chk("rst_ldata",  load_data_o, 32'h0);
        chk("rst_pulses", {29'h0, load_valid_o, timeout_o, misaligned_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // sw, zero-wait memory
        do_op(0, 1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0);
        chk("sw_write", {30'h0, obs_read, obs_write}, 32'h1);
        chk("sw_addr",  obs_addr, 32'h1000_0004);
        chk("sw_mbe",   {28'h0, obs_mbe}, 32'hF);
        chk("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
        chk("sw_stall", stall_cnt, 2);
        chk("sw_total", total, 3);
        chk("sw_nolv",  lv_cnt, 0);

        // sb to the top lane
        do_op(0, 1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
        chk("sb_mbe",   {28'h0, obs_mbe}, 32'h8);
        chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        chk("sb_addr",  obs_addr, 32'h0000_0100);

        // lb with 3 wait cycles
        do_op(1, 0, 3'b000, 32'h0000_0202, 32'h0, 32'h1280_3456, 3);
        chk("lb_reqcyc", req_cnt, 4);
        chk("lb_total",  total, 6);
        chk("lb_stall",  stall_cnt, 5);
        chk("lb_lv",     lv_cnt, 1);
        chk("lb_data",   lv_data, 32'hFFFF_FF80);
        @(negedge clk);
        chk("lb_hold",   load_data_o, 32'hFFFF_FF80);
        chk("lb_lvoff",  {31'h0, load_valid_o}, 32'h0);
        @(posedge clk); #1;

        // lbu same address
        do_op(1, 0, 3'b100, 32'h0000_0202, 32'h0, 32'h1280_3456, 0);
        chk("lbu_data", lv_data, 32'h0000_0080);

        // sh upper half
        do_op(0, 1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 32'h0, 0);
        chk("sh_mbe",   {28'h0, obs_mbe}, 32'hC);
        chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
        chk("sh_addr",  obs_addr, 32'h0000_0004);

        // lh / lhu half selection by off[1]
        do_op(1, 0, 3'b001, 32'h0000_0006, 32'h0, 32'h8001_0000, 1);
        chk("lh_data",  lv_data, 32'hFFFF_8001);
        chk("lh_total", total, 4);
        do_op(1, 0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
        chk("lhu_data", lv_data, 32'h0000_8001);
        chk("lhu_mbe",  {28'h0, obs_mbe}, 32'hC);

        // read wins over write
        do_op(1, 1, 3'b010, 32'h0000_0020, 32'h1111_1111, 32'h0000_0055, 0);
        chk("prio_rw",   {30'h0, obs_read, obs_write}, 32'h2);
        chk("prio_data", lv_data, 32'h0000_0055);

        // lw
        do_op(1, 0, 3'b010, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 2);
        chk("lw_data", lv_data, 32'hCAFE_F00D);

        // reset during second ACCESS cycle of lh
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h0000_0010;
        @(posedge clk); #1;
        valid_i = 1'b0; mem_read_i = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_pre", {31'h0, dmem.dmem_read}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rstmid_read",  {31'h0, dmem.dmem_read}, 32'h0);
        chk("rstmid_addr",  dmem.dmem_address, 32'h0);
        chk("rstmid_mbe",   {28'h0, dmem.dmem_mbe}, 32'h0);
        chk("rstmid_stall", {31'h0, stall_o}, 32'h0);
        chk("rstmid_ldata", load_data_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 32'h0000_FFFF;
        @(posedge clk); #1;
        dmem.dmem_resp = 1'b0;
        lv_cnt = 0; stall_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (load_valid_o) lv_cnt++;
            if (stall_o) stall_cnt++;
        end
        chk("rstmid_nolv",    lv_cnt, 0);
        chk("rstmid_nostall", stall_cnt, 0);
        @(posedge clk); #1;

        // misaligned lw
        do_op(1, 0, 3'b010, 32'h0000_0002, 32'h0, 32'h1122_3344, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_noreq", req_cnt, 0);
        chk("mis_pulse", mis_cnt, 1);
        chk("mis_total", total, 2);
        chk("mis_nolv",  lv_cnt, 0);
`else
        chk("mis_mbe",   {28'h0, obs_mbe}, 32'hF);
        chk("mis_addr",  obs_addr, 32'h0);
        chk("mis_data",  lv_data, 32'h1122_3344);
        chk("mis_nopls", mis_cnt, 0);
`endif

        // invalid instruction: no stall, no request
        valid_i = 1'b0; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h40;
        stall_cnt = 0; req_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (dmem.dmem_read || dmem.dmem_write) req_cnt++;
        end
        chk("noop_stall", stall_cnt, 0);
        chk("noop_req",   req_cnt, 0);
        mem_read_i = 1'b0;
        @(posedge clk); #1;

        // prime load_data_o, then watchdog expiry on lw
        do_op(1, 0, 3'b010, 32'h0000_0030, 32'h0, 32'h0BAD_CAFE, 0);
        chk("pre_to_data", load_data_o, 32'h0BAD_CAFE);
        do_op(1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, -1);
        chk("to_reqcyc", req_cnt, 4);
        chk("to_pulse",  to_cnt, 1);
        chk("to_data",   to_data, 32'h0);
        chk("to_nolv",   lv_cnt, 0);
        chk("to_total",  total, 6);
        chk("to_stall",  stall_cnt, 5);
        @(negedge clk);
        chk("to_reqdrop", {31'h0, dmem.dmem_read}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
